// File: rtl/text_buf_writer.sv
// rtl/text_buf_writer.sv - text-mode writer: ASCII byte stream to text RAM, cursor, control codes, scroll.
// Scrolling rotates top_row instead of moving RAM contents; the reader adds top_row mod ROWS.
module text_buf_writer #(
  parameter int          COLS  = 80,
  parameter int          ROWS  = 30,
  parameter int          AW    = 12,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    chr_in,
  input  logic          chr_valid,
  output logic          chr_ready,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_data,
  output logic          ram_we,
  output logic [6:0]    cursor_col,
  output logic [4:0]    cursor_row,
  output logic [4:0]    top_row,
  output logic          busy
);

  localparam int TOTAL = COLS * ROWS;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_WRITE,
    S_CLEAR,
    S_CLS
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [6:0]      col_q, col_d;
  logic [4:0]      row_q, row_d;
  logic [4:0]      top_q, top_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [7:0]      data_q, data_d;
  logic            rdy_q, rdy_d;
  logic            busy_q, busy_d;
  logic            newline;

  // Physical row base address: one compare-and-subtract replaces the mod.
  function automatic logic [AW-1:0] row_base(input logic [4:0] r, input logic [4:0] t);
    logic [5:0] s;
    s = {1'b0, t} + {1'b0, r};
    if (s >= 6'(ROWS)) s = s - 6'(ROWS);
    return AW'(s) * AW'(COLS);
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    row_d   = row_q;
    top_d   = top_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    newline = 1'b0;

    case (state_q)
      S_INIT, S_CLS: begin
        we_d   = 1'b1;
        addr_d = cnt_q;
        data_d = BLANK;
        if (cnt_q == AW'(TOTAL - 1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_IDLE: begin
        if (chr_valid && rdy_q) begin
          if (chr_in >= 8'h20 && chr_in <= 8'h7E) begin
            state_d = S_WRITE;
            we_d    = 1'b1;
            addr_d  = row_base(row_q, top_q) + AW'(col_q);
            data_d  = chr_in;
          end else begin
            case (chr_in)
              8'h0D: col_d = '0;
              8'h0A: newline = 1'b1;
              8'h08: if (col_q != '0) col_d = col_q - 7'd1;
              8'h0C: begin
                col_d   = '0;
                row_d   = '0;
                top_d   = '0;
                cnt_d   = '0;
                state_d = S_CLS;
              end
              default: ;
            endcase
          end
        end
      end

      S_WRITE: begin
        if (col_q < 7'(COLS - 1)) begin
          col_d   = col_q + 7'd1;
          state_d = S_IDLE;
        end else begin
          newline = 1'b1;
        end
      end

      S_CLEAR: begin
        we_d   = 1'b1;
        addr_d = row_base(row_q, top_q) + cnt_q;
        data_d = BLANK;
        if (cnt_q == AW'(COLS - 1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = S_INIT;
    endcase

    // On the bottom row the oldest physical row becomes the new bottom and is blanked.
    if (newline) begin
      col_d   = '0;
      cnt_d   = '0;
      state_d = S_CLEAR;
      if (row_q < 5'(ROWS - 1)) begin
        row_d = row_q + 5'd1;
      end else begin
        top_d = (top_q == 5'(ROWS - 1)) ? 5'd0 : top_q + 5'd1;
      end
    end

    rdy_d  = (state_d == S_IDLE);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      top_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= BLANK;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      row_q   <= row_d;
      top_q   <= top_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
    end
  end

  assign chr_ready  = rdy_q;
  assign ram_we     = we_q;
  assign ram_addr   = addr_q;
  assign ram_data   = data_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;
  assign top_row    = top_q;
  assign busy       = busy_q;

endmodule
